// File: rtl/gates7_pkg.sv
// Shared definitions for the seven-gate block and its result checker.
//   - f_vec bit-index constants (bit 6..0 = and, or, not, nand, nor, xor, xnor)
//   - checker state enum
//   - gates7_expected(): golden 7-bit output vector for an (a, b) pair
package gates7_pkg;

  localparam int F_AND  = 6;
  localparam int F_OR   = 5;
  localparam int F_NOT  = 4;
  localparam int F_NAND = 3;
  localparam int F_NOR  = 2;
  localparam int F_XOR  = 1;
  localparam int F_XNOR = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [6:0] gates7_expected(input logic a, input logic b);
    logic [6:0] e;
    e         = '0;
    e[F_AND]  = a & b;
    e[F_OR]   = a | b;
    e[F_NOT]  = ~a;
    e[F_NAND] = ~(a & b);
    e[F_NOR]  = ~(a | b);
    e[F_XOR]  = a ^ b;
    e[F_XNOR] = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gates7_result_checker_golden.sv
// gates7_golden: combinational golden model of the seven-gate block.
// Ports:
//   a, b      - gate inputs
//   expected  - golden outputs, bit 6..0 = {and, or, not, nand, nor, xor, xnor}
module gates7_golden
  import gates7_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [6:0] expected
);

  assign expected = gates7_expected(a, b);

endmodule

// File: rtl/gates7_result_checker.sv
// gates7_result_checker: compares sampled outputs of the seven-gate block
// against the golden truth table, counts samples/mismatches, tracks (a, b)
// coverage and captures the first failure. done/pass rise once all four
// input combinations have been observed.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start             - one-cycle pulse: clear results and enter RUN
//   in_valid, a, b    - sample strobe and gate inputs
//   f_vec             - gate outputs {and, or, not, nand, nor, xor, xnor}
//   busy, done, pass  - status (registered)
//   fail_seen         - sticky mismatch flag since last start
//   sample_cnt        - checked samples, saturating
//   err_cnt           - samples with any mismatch, saturating
//   coverage          - bit {a,b} set once that combination is sampled
//   first_fail_ab     - {a,b} of first failing sample
//   first_fail_mask   - expected ^ f_vec of first failing sample
module gates7_result_checker
  import gates7_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic [6:0]       f_vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail_seen,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       coverage,
  output logic [1:0]       first_fail_ab,
  output logic [6:0]       first_fail_mask
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] smp_q, smp_d, err_q, err_d;
  logic [3:0]       cov_q, cov_d;
  logic [1:0]       ffab_q, ffab_d;
  logic [6:0]       ffmask_q, ffmask_d;

  logic [6:0]       expected;
  logic [6:0]       mask;
  logic             mism;
  logic [3:0]       cov_upd;
  logic [CNT_W-1:0] err_upd;

  gates7_golden u_golden (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  assign mask    = expected ^ f_vec;
  assign mism    = |mask;
  assign cov_upd = cov_q | (4'b0001 << {a, b});
  assign err_upd = (mism && err_q != CNT_MAX) ? err_q + 1'b1 : err_q;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    smp_d    = smp_q;
    err_d    = err_q;
    cov_d    = cov_q;
    ffab_d   = ffab_q;
    ffmask_d = ffmask_q;

    if (start) begin
      // start in any state clears everything; a coincident sample is dropped
      state_d  = RUN;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      pass_d   = 1'b0;
      fail_d   = 1'b0;
      smp_d    = '0;
      err_d    = '0;
      cov_d    = '0;
      ffab_d   = '0;
      ffmask_d = '0;
    end else if (state_q == RUN && in_valid) begin
      smp_d = (smp_q != CNT_MAX) ? smp_q + 1'b1 : smp_q;
      err_d = err_upd;
      cov_d = cov_upd;
      if (mism && !fail_q) begin
        fail_d   = 1'b1;
        ffab_d   = {a, b};
        ffmask_d = mask;
      end
      if (cov_upd == 4'hF) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_upd == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      smp_q    <= '0;
      err_q    <= '0;
      cov_q    <= '0;
      ffab_q   <= '0;
      ffmask_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      smp_q    <= smp_d;
      err_q    <= err_d;
      cov_q    <= cov_d;
      ffab_q   <= ffab_d;
      ffmask_q <= ffmask_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail_seen       = fail_q;
  assign sample_cnt      = smp_q;
  assign err_cnt         = err_q;
  assign coverage        = cov_q;
  assign first_fail_ab   = ffab_q;
  assign first_fail_mask = ffmask_q;

endmodule

// File: tb/tb_gates7_result_checker.sv
module tb_gates7_result_checker;

  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, start, in_valid, a, b;
  logic [6:0]       f_vec;
  logic             busy, done, pass, fail_seen;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [3:0]       coverage;
  logic [1:0]       first_fail_ab;
  logic [6:0]       first_fail_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gates7_result_checker #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .in_valid        (in_valid),
    .a               (a),
    .b               (b),
    .f_vec           (f_vec),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_seen       (fail_seen),
    .sample_cnt      (sample_cnt),
    .err_cnt         (err_cnt),
    .coverage        (coverage),
    .first_fail_ab   (first_fail_ab),
    .first_fail_mask (first_fail_mask)
  );

  // Golden vector from the truth-table definitions, using integer arithmetic.
  function automatic logic [6:0] golden(input int ia, input int ib);
    int s;
    logic [6:0] r;
    s = ia + ib;
    r[6] = (s == 2);       // and
    r[5] = (s >= 1);       // or
    r[4] = (ia == 0);      // not a
    r[3] = (s != 2);       // nand
    r[2] = (s == 0);       // nor
    r[1] = (s == 1);       // xor
    r[0] = (s != 1);       // xnor
    return r;
  endfunction

  // Behavioural reference: mode 0=idle, 1=running, 2=finished.
  int         m_mode = 0;
  int         m_smp = 0, m_err = 0;
  bit         m_seen [4];
  bit         m_pass = 0, m_fail = 0;
  int         m_ffab = 0;
  logic [6:0] m_ffmask = '0;
  bit         model_on = 0;

  function automatic logic [3:0] m_cov();
    logic [3:0] c;
    for (int i = 0; i < 4; i++) c[i] = m_seen[i];
    return c;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_smp = 0; m_err = 0; m_pass = 0; m_fail = 0;
      m_ffab = 0; m_ffmask = '0;
      for (int i = 0; i < 4; i++) m_seen[i] = 0;
    end else if (start) begin
      m_mode = 1; m_smp = 0; m_err = 0; m_pass = 0; m_fail = 0;
      m_ffab = 0; m_ffmask = '0;
      for (int i = 0; i < 4; i++) m_seen[i] = 0;
    end else if (m_mode == 1 && in_valid) begin
      logic [6:0] mk;
      int idx;
      int nseen;
      mk  = golden(int'(a), int'(b)) ^ f_vec;
      idx = 2 * int'(a) + int'(b);
      if (m_smp < MAXC) m_smp++;
      if (mk != 0) begin
        if (m_err < MAXC) m_err++;
        if (!m_fail) begin
          m_fail = 1; m_ffab = idx; m_ffmask = mk;
        end
      end
      m_seen[idx] = 1;
      nseen = 0;
      for (int i = 0; i < 4; i++) nseen += int'(m_seen[i]);
      if (nseen == 4) begin
        m_mode = 2;
        m_pass = (m_err == 0);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_on) begin
      checks++;
      if (busy !== (m_mode == 1) || done !== (m_mode == 2) || pass !== m_pass ||
          fail_seen !== m_fail || int'(sample_cnt) != m_smp || int'(err_cnt) != m_err ||
          coverage !== m_cov() || int'(first_fail_ab) != m_ffab ||
          first_fail_mask !== m_ffmask) begin
        errors++;
        $display("FAIL model_cmp t=%0t got busy=%b done=%b pass=%b fs=%b smp=%0d err=%0d cov=%b ffab=%b ffm=%b want busy=%b done=%b pass=%b fs=%b smp=%0d err=%0d cov=%b ffab=%0d ffm=%b",
                 $time, busy, done, pass, fail_seen, sample_cnt, err_cnt, coverage,
                 first_fail_ab, first_fail_mask, m_mode == 1, m_mode == 2, m_pass,
                 m_fail, m_smp, m_err, m_cov(), m_ffab, m_ffmask);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic cyc(input bit rs, input bit st, input bit v, input bit ia, input bit ib,
                     input logic [6:0] f);
    @(negedge clk);
    reset = rs; start = st; in_valid = v; a = ia; b = ib; f_vec = f;
  endtask

  task automatic samp(input bit ia, input bit ib, input logic [6:0] flip);
    cyc(0, 0, 1, ia, ib, golden(int'(ia), int'(ib)) ^ flip);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 7'd0);
  endtask

  initial begin
    reset = 1; start = 0; in_valid = 0; a = 0; b = 0; f_vec = '0;
    repeat (3) @(negedge clk);
    model_on = 1;
    idle();
    chk("reset_busy", int'(busy), 0);
    chk("reset_smp", int'(sample_cnt), 0);

    // Clean walk of the four combinations
    cyc(0, 1, 0, 0, 0, 7'd0);
    cyc(0, 0, 1, 0, 0, 7'b0011101);
    cyc(0, 0, 1, 1, 0, 7'b0101010);
    cyc(0, 0, 1, 0, 1, 7'b0111010);
    cyc(0, 0, 1, 1, 1, 7'b1100001);
    idle();
    chk("walk_done", int'(done), 1);
    chk("walk_pass", int'(pass), 1);
    chk("walk_smp", int'(sample_cnt), 4);
    chk("walk_cov", int'(coverage), 15);

    // xnor stuck-1 at (1,0)
    cyc(0, 1, 0, 0, 0, 7'd0);
    samp(0, 0, 7'd0);
    cyc(0, 0, 1, 1, 0, 7'b0101011);
    samp(0, 1, 7'd0);
    samp(1, 1, 7'd0);
    idle();
    chk("stuck_err", int'(err_cnt), 1);
    chk("stuck_ffab", int'(first_fail_ab), 2);
    chk("stuck_ffmask", int'(first_fail_mask), 1);
    chk("stuck_pass", int'(pass), 0);
    chk("stuck_done", int'(done), 1);

    // Repeated (0,0) before the rest
    cyc(0, 1, 0, 0, 0, 7'd0);
    repeat (10) samp(0, 0, 7'd0);
    idle();
    chk("rep_cov1", int'(coverage), 1);
    chk("rep_busy", int'(busy), 1);
    samp(0, 1, 7'd0);
    samp(1, 0, 7'd0);
    idle();
    chk("rep_cov3", int'(coverage), 7);
    chk("rep_notdone", int'(done), 0);
    samp(1, 1, 7'd0);
    idle();
    chk("rep_smp", int'(sample_cnt), 13);
    chk("rep_done", int'(done), 1);

    // Restart mid-run, with a coincident sample that must be dropped
    cyc(0, 1, 0, 0, 0, 7'd0);
    samp(0, 0, 7'd0);
    samp(1, 0, 7'h10);
    cyc(0, 1, 1, 1, 1, 7'h7F);
    idle();
    chk("restart_smp", int'(sample_cnt), 0);
    chk("restart_fs", int'(fail_seen), 0);
    chk("restart_busy", int'(busy), 1);
    samp(0, 0, 7'd0); samp(0, 1, 7'd0); samp(1, 0, 7'd0); samp(1, 1, 7'd0);
    idle();
    chk("restart_pass", int'(pass), 1);

    // Reset in DONE, then reset with start+valid mid-run
    cyc(1, 0, 0, 0, 0, 7'd0);
    idle();
    chk("rst_done", int'(done), 0);
    cyc(0, 1, 0, 0, 0, 7'd0);
    samp(0, 0, 7'h40);
    cyc(1, 1, 1, 1, 1, 7'h7F);
    idle();
    chk("rst_run_busy", int'(busy), 0);
    chk("rst_run_err", int'(err_cnt), 0);
    samp(1, 1, 7'h01);
    idle();
    chk("idle_ignored", int'(sample_cnt), 0);

    // Counter saturation
    cyc(0, 1, 0, 0, 0, 7'd0);
    repeat (MAXC + 45) samp(0, 0, 7'h04);
    samp(0, 1, 7'd0); samp(1, 0, 7'd0); samp(1, 1, 7'd0);
    idle();
    chk("sat_err", int'(err_cnt), MAXC);
    chk("sat_smp", int'(sample_cnt), MAXC);
    chk("sat_pass", int'(pass), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit ia, ib;
      logic [6:0] fl;
      ia = 1'($urandom_range(0, 1));
      ib = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 3) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'd0;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 3) != 0, ia, ib, golden(int'(ia), int'(ib)) ^ fl);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
